// File: rtl/led_display_sched.sv
// LED bank scheduler: a prescaled pattern engine (bounce/rotate/blink/hold) that
// lends the bank to a message requester for a set number of ticks, then resumes.
module led_display_sched #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRESC_W-1:0] step_div,
    input  logic [1:0]         mode,
    input  logic               pause,
    input  logic               msg_req,
    input  logic [WIDTH-1:0]   msg_data,
    input  logic [3:0]         msg_steps,
    output logic               msg_gnt,
    output logic               msg_done,
    output logic               step_pulse,
    output logic [WIDTH-1:0]   led
);

    typedef enum logic {ST_PAT, ST_MSG} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [WIDTH-1:0] PAT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] PAT_ALL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] PAT_NONE = {WIDTH{1'b0}};

    state_t             state_q;
    dir_t               dir_q, dir_d;
    logic [PRESC_W-1:0] cnt_q;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   mdat_q;
    logic [WIDTH-1:0]   led_q;
    logic [3:0]         rem_q;
    logic               step_pulse_q;
    logic               msg_gnt_q;
    logic               msg_done_q;

    logic               tick;
    logic               pat_onehot;
    logic [WIDTH-1:0]   pat_rol;
    logic [WIDTH-1:0]   pat_shl;
    logic [WIDTH-1:0]   pat_shr;
    logic [3:0]         rem_load;

    // A lowered step_div below cnt fires immediately thanks to the >= compare.
    assign tick       = (cnt_q >= step_div) && !pause;
    assign pat_onehot = (pat_q != PAT_NONE) && ((pat_q & (pat_q - PAT_ONE)) == PAT_NONE);
    assign pat_shl    = pat_q << 1;
    assign pat_shr    = pat_q >> 1;
    assign rem_load   = (msg_steps == 4'd0) ? 4'd1 : msg_steps;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rol
            assign pat_rol[gi] = pat_q[(gi + WIDTH - 1) % WIDTH];
        end
    endgenerate

    always_comb begin
        pat_d = pat_q;
        dir_d = dir_q;
        case (mode)
            2'b00: begin
                if (!pat_onehot) begin
                    pat_d = PAT_ONE;
                    dir_d = DIR_UP;
                end else if (dir_q == DIR_UP) begin
                    pat_d = pat_shl;
                    if (pat_shl[WIDTH-1]) dir_d = DIR_DOWN;
                end else begin
                    pat_d = pat_shr;
                    if (pat_shr[0]) dir_d = DIR_UP;
                end
            end
            2'b01:   pat_d = pat_onehot ? pat_rol : PAT_ONE;
            2'b10:   pat_d = (pat_q == PAT_ALL) ? PAT_NONE : PAT_ALL;
            default: pat_d = pat_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PAT;
            dir_q        <= DIR_UP;
            cnt_q        <= '0;
            pat_q        <= PAT_ONE;
            mdat_q       <= '0;
            led_q        <= PAT_ONE;
            rem_q        <= '0;
            step_pulse_q <= 1'b0;
            msg_gnt_q    <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            msg_gnt_q  <= 1'b0;
            msg_done_q <= 1'b0;

            if (pause) begin
                step_pulse_q <= 1'b0;
            end else if (cnt_q >= step_div) begin
                cnt_q        <= '0;
                step_pulse_q <= 1'b1;
            end else begin
                cnt_q        <= cnt_q + PRESC_W'(1);
                step_pulse_q <= 1'b0;
            end

            case (state_q)
                ST_PAT: begin
                    led_q <= pat_q;
                    if (tick) begin
                        // A granted tick is spent on the handover, not on the pattern.
                        if (msg_req) begin
                            mdat_q    <= msg_data;
                            rem_q     <= rem_load;
                            msg_gnt_q <= 1'b1;
                            state_q   <= ST_MSG;
                        end else begin
                            pat_q <= pat_d;
                            dir_q <= dir_d;
                        end
                    end
                end
                ST_MSG: begin
                    led_q <= mdat_q;
                    if (tick) begin
                        rem_q <= rem_q - 4'd1;
                        if (rem_q == 4'd1) begin
                            msg_done_q <= 1'b1;
                            state_q    <= ST_PAT;
                        end
                    end
                end
                default: state_q <= ST_PAT;
            endcase
        end
    end

    assign msg_gnt    = msg_gnt_q;
    assign msg_done   = msg_done_q;
    assign step_pulse = step_pulse_q;
    assign led        = led_q;

endmodule

// File: tb/tb_led_display_sched.sv
// Directed bench for led_display_sched: per-tick expectations queued as stimulus is set up.
module tb_led_display_sched;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 24;
    localparam int BOUND   = 300;

    logic               clk;
    logic               reset;
    logic [PRESC_W-1:0] step_div;
    logic [1:0]         mode;
    logic               pause;
    logic               msg_req;
    logic [WIDTH-1:0]   msg_data;
    logic [3:0]         msg_steps;
    logic               msg_gnt;
    logic               msg_done;
    logic               step_pulse;
    logic [WIDTH-1:0]   led;

    typedef struct packed {
        logic [7:0] led;
        logic       gnt;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   last_wait;
    int   tick_no;

    led_display_sched #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .step_div   (step_div),
        .mode       (mode),
        .pause      (pause),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_steps  (msg_steps),
        .msg_gnt    (msg_gnt),
        .msg_done   (msg_done),
        .step_pulse (step_pulse),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic g, input logic d);
        exp_t e;
        e.led  = l;
        e.gnt  = g;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; consumes one step_pulse and samples led one cycle later.
    task automatic wait_tick(output int waited, output logic g, output logic d, output logic [7:0] l);
        waited = 0;
        while (step_pulse !== 1'b1 && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        chk("tick_timeout", 32'(waited < BOUND), 32'd1);
        g = msg_gnt;
        d = msg_done;
        @(negedge clk);
        l = led;
    endtask

    task automatic drain();
        exp_t       e;
        int         w;
        logic       g, d;
        logic [7:0] l;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(w, g, d, l);
            last_wait = w;
            tick_no++;
            $display("tick %0d: led=%02h gnt=%0b done=%0b (exp %02h %0b %0b) waited=%0d",
                     tick_no, l, g, d, e.led, e.gnt, e.done, w);
            chk("led", 32'(l), 32'(e.led));
            chk("gnt", 32'(g), 32'(e.gnt));
            chk("done", 32'(d), 32'(e.done));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_wait = 0;
        tick_no   = 0;
        reset     = 1'b1;
        step_div  = 24'd2;
        mode      = 2'b00;
        pause     = 1'b0;
        msg_req   = 1'b0;
        msg_data  = 8'h00;
        msg_steps = 4'd0;

        // Reset state and bounce over 15 ticks
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 32'h01);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_gnt", 32'(msg_gnt), 32'd0);
        chk("rst_done", 32'(msg_done), 32'd0);
        reset = 1'b0;
        push(8'h02, 0, 0); push(8'h04, 0, 0); push(8'h08, 0, 0); push(8'h10, 0, 0);
        push(8'h20, 0, 0); push(8'h40, 0, 0); push(8'h80, 0, 0); push(8'h40, 0, 0);
        push(8'h20, 0, 0); push(8'h10, 0, 0); push(8'h08, 0, 0); push(8'h04, 0, 0);
        push(8'h02, 0, 0); push(8'h01, 0, 0); push(8'h02, 0, 0);
        drain();
        chk("period_div2", 32'(last_wait), 32'd2);

        // Rotate every cycle, then blink
        step_div = 24'd0;
        mode     = 2'b01;
        push(8'h04, 0, 0); push(8'h08, 0, 0); push(8'h10, 0, 0); push(8'h20, 0, 0);
        push(8'h40, 0, 0); push(8'h80, 0, 0); push(8'h01, 0, 0); push(8'h02, 0, 0);
        drain();
        chk("period_div0", 32'(last_wait), 32'd0);
        mode = 2'b10;
        push(8'h04, 0, 0); push(8'hFF, 0, 0); push(8'h00, 0, 0); push(8'hFF, 0, 0); push(8'h00, 0, 0);
        drain();

        // Message A5 for 3 ticks in the middle of a bounce
        reset    = 1'b1;
        step_div = 24'd2;
        mode     = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(8'h02, 0, 0); push(8'h04, 0, 0); push(8'h08, 0, 0);
        drain();
        msg_req   = 1'b1;
        msg_data  = 8'hA5;
        msg_steps = 4'd3;
        push(8'hA5, 1, 0);
        drain();
        msg_req = 1'b0;
        push(8'hA5, 0, 0); push(8'hA5, 0, 0); push(8'h08, 0, 1); push(8'h10, 0, 0);
        drain();

        // Zero-length message and re-grant while request stays high
        msg_req   = 1'b1;
        msg_data  = 8'h3C;
        msg_steps = 4'd0;
        push(8'h3C, 1, 0); push(8'h10, 0, 1); push(8'h3C, 1, 0);
        drain();
        msg_req = 1'b0;
        push(8'h10, 0, 1); push(8'h20, 0, 0);
        drain();

        // Pause in MSG with two ticks remaining
        msg_req   = 1'b1;
        msg_data  = 8'h5A;
        msg_steps = 4'd3;
        push(8'h5A, 1, 0);
        drain();
        msg_req = 1'b0;
        push(8'h5A, 0, 0);
        drain();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("pause_quiet", 32'({step_pulse, msg_gnt, msg_done}), 32'd0);
            chk("pause_led", 32'(led), 32'h5A);
        end
        pause = 1'b0;
        push(8'h5A, 0, 0);
        drain();
        chk("resume_wait", 32'(last_wait), 32'd2);
        push(8'h20, 0, 1); push(8'h40, 0, 0);
        drain();

        // Reset during a message
        msg_req   = 1'b1;
        msg_data  = 8'hC3;
        msg_steps = 4'd5;
        push(8'hC3, 1, 0);
        drain();
        msg_req = 1'b0;
        #2;
        reset    = 1'b1;
        step_div = 24'd100;
        mode     = 2'b11;
        #1;
        chk("mid_rst_led", 32'(led), 32'h01);
        chk("mid_rst_done", 32'(msg_done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(msg_done), 32'd0);
        end
        reset = 1'b0;

        // Lower step_div below cnt=50
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("div100_quiet", 32'({step_pulse, msg_done}), 32'd0);
        end
        step_div = 24'd5;
        push(8'h01, 0, 0);
        drain();
        chk("forced_tick_wait", 32'(last_wait), 32'd1);
        push(8'h01, 0, 0);
        drain();
        chk("period_div5", 32'(last_wait), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_display_sched.md
Name: led_display_sched

Overview:
- Sequences and shares one WIDTH-bit LED bank between a free-running pattern engine and an external message requester.
- A programmable prescaler generates step ticks. On each tick the pattern engine advances: bounce, rotate, blink or hold.
- A requester can take the bank for a programmed number of steps. The pattern then resumes exactly where it stopped.
- Sits between system-clock logic and board LED pins.

Parameters:
- WIDTH, 8, LED bank width (>=2).
- PRESC_W, 24, prescaler counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_div  in  PRESC_W  tick period minus one, in clk cycles.
- mode  in  2  00 bounce, 01 rotate-left, 10 blink, 11 hold.
- pause  in  1  freezes prescaler, pattern and message countdown.
- msg_req  in  1  level request for the LED bank.
- msg_data  in  WIDTH  word to display; sampled on grant.
- msg_steps  in  4  display duration in ticks; 0 is treated as 1.
- msg_gnt  out  1  one-cycle grant pulse.
- msg_done  out  1  one-cycle pulse when the message period ends.
- step_pulse  out  1  one-cycle tick strobe.
- led  out  WIDTH  registered LED drive.

Behaviour:
- Reset (async): cnt=0, step_pulse=0, pat=1 (bit0), dir=up, state=PAT, msg_gnt=0, msg_done=0, led=1. All outputs are registered.
- Prescaler:
  - If pause=1: cnt holds and step_pulse=0.
  - Else if cnt>=step_div: cnt<=0 and step_pulse<=1 for the next cycle.
  - Else cnt<=cnt+1 and step_pulse<=0.
  - step_div=0 gives a tick every cycle.
  - Lowering step_div below the current cnt forces a tick on the next cycle.
  - Internal tick = (cnt>=step_div) && !pause. step_pulse is that tick delayed one cycle.
- Pattern engine: advances on the internal tick, only in state PAT.
  - bounce:
    - If pat is not one-hot: pat<=1, dir=up.
    - up: pat<=pat<<1. Set dir=down when the new pat has its MSB set.
    - down: pat<=pat>>1. Set dir=up when the new pat has bit0 set.
    - Sequence for WIDTH=8: 01,02,04,08,10,20,40,80,40,...,02,01,02. Each endpoint appears for exactly one tick.
  - rotate-left:
    - If pat is not one-hot: pat<=1.
    - Else pat<=pat rotated left by 1 (80 -> 01).
  - blink: pat<=(pat=={WIDTH{1}}) ? 0 : {WIDTH{1}}.
  - hold: pat unchanged.
  - A mode change has no immediate effect; the new rule applies at the next tick.
- State machine:
  - PAT:
    - led follows pat, one cycle after pat updates.
    - On a tick with msg_req=1:
      - latch msg_data into mdat;
      - load rem = max(msg_steps,1);
      - pulse msg_gnt for one cycle (same cycle as the state change);
      - go to MSG.
    - The pattern does NOT advance on that tick.
    - msg_req is only arbitrated on ticks.
  - MSG:
    - led=mdat; pat and dir are frozen.
    - On each tick: rem<=rem-1.
    - When rem==1 at a tick: pulse msg_done, go to PAT. The pattern advances on the next tick, not this one.
    - msg_req is ignored while in MSG.
    - A requester that still holds msg_req after msg_done is re-granted at the next tick. Back-to-back messages are allowed.
- pause=1 in any state freezes everything except the outputs, which hold. No gnt or done pulses occur while paused.
- Reset mid-message: immediately return to PAT with pat=1. No msg_done is issued.

Test Plan:
- Reset, mode=00, step_div=2, pause=0 -> step_pulse every 3 cycles. led steps 01,02,...,80,40,...,01,02 over 15 ticks.
- mode=01, step_div=0 -> led 01,02,...,80,01 on consecutive cycles. Switch to mode=10 -> FF,00,FF alternating each cycle.
- Bounce running with led=08, msg_req=1, msg_data=A5, msg_steps=3 -> msg_gnt at the next tick. led=A5 for 3 ticks, then msg_done. The next tick shows led=10.
- msg_steps=0, msg_data=3C -> led=3C for exactly 1 tick, then msg_done. msg_req held high -> re-grant at the following tick.
- pause=1 during MSG with rem=2 for 20 cycles -> led, cnt and rem frozen, no pulses. Release pause -> 2 more ticks, then msg_done.
- Assert reset during MSG -> led=01 and state PAT immediately, with no msg_done pulse. Separately, change step_div from 100 to 5 while cnt=50 -> tick on the next cycle.
